// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a 2^ADDR_W x DATA_W register file, burst access,
// a local read port and write notifications. Everything runs on clk; SPI pins are oversampled.
`timescale 1ns/1ps
module spi_slave_regfile #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    input  logic              mem_initial,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    input  logic [ADDR_W-1:0] lcl_rd_addr,
    output logic [DATA_W-1:0] lcl_rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_ADDR, S_DATA} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES:0]   flush_q, flush_d;
    logic                   sck_prev_q, sck_prev_d, sck_rise_q, sck_rise_d, sck_fall_q, sck_fall_d;
    logic                   ss_q, ss_d, mosi_q, mosi_d, armed_q, armed_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      rx_q, rx_d, tx_q, tx_d, wr_data_q, wr_data_d, lcl_q, lcl_d;
    logic                   miso_q, miso_d, oe_q, oe_d, wr_valid_q, wr_valid_d, ferr_q, ferr_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];
    logic [ADDR_W-1:0]      addr_shift_c;
    logic [DATA_W-1:0]      rx_word_c;
    logic                   commit_c;

    assign MISO        = miso_q;
    assign miso_oe     = oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = ferr_q;
    assign lcl_rd_data = lcl_q;

    // Pin synchronisers plus one registered edge/level stage, so all events share one latency.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        sck_rise_d  = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
        sck_fall_d  = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
        ss_d        = ss_sync_q[SYNC_STAGES-1];
        mosi_d      = mosi_sync_q[SYNC_STAGES-1];
        flush_d     = {flush_q[SYNC_STAGES-1:0], 1'b1};
        // A frame already running at reset release is skipped until SS has been seen high.
        armed_d     = armed_q | (flush_q[SYNC_STAGES] & ss_q);
        oe_d        = ~ss_q;
    end

    // Frame FSM, shift registers and register-file update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        ferr_d       = 1'b0;
        mem_d        = mem_q;
        lcl_d        = mem_q[lcl_rd_addr];
        commit_c     = 1'b0;
        addr_shift_c = ADDR_W'({addr_q, mosi_q});
        rx_word_c    = DATA_W'({rx_q, mosi_q});

        if (ss_q) begin
            if (state_q == S_ADDR || (state_q == S_DATA && cnt_q != '0)) ferr_d = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    cnt_d  = '0;
                    if (armed_q) state_d = S_CMD;
                end
                S_CMD: begin
                    if (sck_rise_q) begin
                        rw_d    = mosi_q;
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end
                end
                S_ADDR: begin
                    if (sck_rise_q) begin
                        addr_d = addr_shift_c;
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            if (rw_q) begin
                                tx_d   = mem_initial ? '0 : mem_q[addr_shift_c];
                                addr_d = addr_shift_c + ADDR_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (sck_rise_q) begin
                        if (!rw_q) rx_d = rx_word_c;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d  = '0;
                            addr_d = addr_q + ADDR_W'(1);
                            if (rw_q) tx_d = mem_initial ? '0 : mem_q[addr_q];
                            else      commit_c = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall_q && rw_q) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Clear wins over a same-cycle commit and also hides its notification.
        if (mem_initial) begin
            mem_d = '{default: '0};
        end else if (commit_c) begin
            mem_d[addr_q] = rx_word_c;
            wr_valid_d    = 1'b1;
            wr_addr_d     = addr_q;
            wr_data_d     = rx_word_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sck_prev_q  <= 1'b0;
            sck_rise_q  <= 1'b0;
            sck_fall_q  <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ferr_q      <= 1'b0;
            lcl_q       <= '0;
            mem_q       <= '{default: '0};
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            sck_prev_q  <= sck_prev_d;
            sck_rise_q  <= sck_rise_d;
            sck_fall_q  <= sck_fall_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ferr_q      <= ferr_d;
            lcl_q       <= lcl_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: write, read, burst wrap, frame error, mem_initial, async reset.
`timescale 1ns/1ps
module tb_spi_slave_regfile;
    localparam int HALF = 80;

    logic       clk = 1'b0, rst_n = 1'b0, SCK = 1'b0, SS = 1'b1, MOSI = 1'b0, mem_initial = 1'b0;
    logic       MISO, miso_oe, wr_valid, frame_err;
    logic [3:0] wr_addr, lcl_rd_addr = 4'h0;
    logic [7:0] wr_data, lcl_rd_data;

    int n_vec = 0, n_err = 0, wr_cnt = 0, ferr_cnt = 0;
    logic [63:0] rx;
    logic        oe_all;
    logic [7:0]  rd;

    spi_slave_regfile #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .miso_oe(miso_oe), .mem_initial(mem_initial), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
        .lcl_rd_addr(lcl_rd_addr), .lcl_rd_data(lcl_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid)  wr_cnt   <= wr_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    // Master side of one frame: n bits MSB first, MISO captured at each SCK rise.
    task automatic spi_frame(input logic [63:0] tx, input int n, output logic [63:0] rxv, output logic oe);
        @(posedge clk); #1;
        rxv = '0; oe = 1'b1;
        SS = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = tx[i];
            #HALF;
            rxv[i] = MISO;
            oe = oe & miso_oe;
            SCK = 1'b1;
            #HALF;
            SCK = 1'b0;
        end
        #HALF;
        SS = 1'b1;
        #(4*HALF);
    endtask

    task automatic lcl_read(input logic [3:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        lcl_rd_addr = a;
        @(posedge clk); #1;
        d = lcl_rd_data;
    endtask

    task automatic test_reset;
        n_vec++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_vec++; if (miso_oe !== 1'b0)   begin n_err++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
        n_vec++; if (wr_valid !== 1'b0)  begin n_err++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        n_vec++; if (wr_addr !== 4'h0)   begin n_err++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        n_vec++; if (wr_data !== 8'h00)  begin n_err++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        lcl_read(4'hA, rd);
        n_vec++; if (rd !== 8'h00)       begin n_err++; $display("FAIL reset_mem: got %h expected 00", rd); end
    endtask

    task automatic test_single_write;
        int w0;
        w0 = wr_cnt;
        spi_frame({51'd0, 1'b0, 4'hA, 8'h5C}, 13, rx, oe_all);
        n_vec++; if (wr_cnt !== w0 + 1)  begin n_err++; $display("FAIL wr_pulses: got %0d expected %0d", wr_cnt - w0, 1); end
        n_vec++; if (wr_addr !== 4'hA)   begin n_err++; $display("FAIL wr_addr: got %h expected a", wr_addr); end
        n_vec++; if (wr_data !== 8'h5C)  begin n_err++; $display("FAIL wr_data: got %h expected 5c", wr_data); end
        n_vec++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL miso_idle: got %b expected 0", MISO); end
        lcl_read(4'hA, rd);
        n_vec++; if (rd !== 8'h5C)       begin n_err++; $display("FAIL lcl_after_write: got %h expected 5c", rd); end
    endtask

    task automatic test_single_read;
        spi_frame({51'd0, 1'b1, 4'hA, 8'h00}, 13, rx, oe_all);
        n_vec++; if (rx[7:0] !== 8'h5C)  begin n_err++; $display("FAIL read_data: got %h expected 5c", rx[7:0]); end
        n_vec++; if (oe_all !== 1'b1)    begin n_err++; $display("FAIL read_oe_low_in_frame: got %b expected 1", oe_all); end
        n_vec++; if (miso_oe !== 1'b0)   begin n_err++; $display("FAIL read_oe_after_frame: got %b expected 0", miso_oe); end
        n_vec++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL miso_after_read: got %b expected 0", MISO); end
    endtask

    task automatic test_burst_wrap;
        int w0;
        w0 = wr_cnt;
        spi_frame({43'd0, 1'b0, 4'hF, 8'h11, 8'h22}, 21, rx, oe_all);
        n_vec++; if (wr_cnt !== w0 + 2)  begin n_err++; $display("FAIL burst_pulses: got %0d expected %0d", wr_cnt - w0, 2); end
        n_vec++; if (wr_addr !== 4'h0)   begin n_err++; $display("FAIL burst_wr_addr: got %h expected 0", wr_addr); end
        n_vec++; if (wr_data !== 8'h22)  begin n_err++; $display("FAIL burst_wr_data: got %h expected 22", wr_data); end
        lcl_read(4'hF, rd);
        n_vec++; if (rd !== 8'h11)       begin n_err++; $display("FAIL burst_mem_f: got %h expected 11", rd); end
        lcl_read(4'h0, rd);
        n_vec++; if (rd !== 8'h22)       begin n_err++; $display("FAIL burst_mem_0: got %h expected 22", rd); end
        spi_frame({43'd0, 1'b1, 4'hF, 16'h0000}, 21, rx, oe_all);
        n_vec++; if (rx[15:0] !== 16'h1122) begin n_err++; $display("FAIL burst_read: got %h expected 1122", rx[15:0]); end
    endtask

    task automatic test_frame_error;
        int w0, f0;
        w0 = wr_cnt; f0 = ferr_cnt;
        n_vec++; if (f0 !== 0)           begin n_err++; $display("FAIL ferr_on_good_frames: got %0d expected 0", f0); end
        spi_frame({54'd0, 1'b0, 4'h3, 5'b10101}, 10, rx, oe_all);
        n_vec++; if (ferr_cnt !== f0 + 1) begin n_err++; $display("FAIL ferr_pulse: got %0d expected %0d", ferr_cnt - f0, 1); end
        n_vec++; if (wr_cnt !== w0)      begin n_err++; $display("FAIL ferr_no_write: got %0d expected 0", wr_cnt - w0); end
        lcl_read(4'h3, rd);
        n_vec++; if (rd !== 8'h00)       begin n_err++; $display("FAIL ferr_mem_kept: got %h expected 00", rd); end
        spi_frame({51'd0, 1'b0, 4'h3, 8'hA7}, 13, rx, oe_all);
        n_vec++; if (wr_cnt !== w0 + 1)  begin n_err++; $display("FAIL ferr_retry_pulse: got %0d expected 1", wr_cnt - w0); end
        n_vec++; if (ferr_cnt !== f0 + 1) begin n_err++; $display("FAIL ferr_retry_clean: got %0d expected 1", ferr_cnt - f0); end
        lcl_read(4'h3, rd);
        n_vec++; if (rd !== 8'hA7)       begin n_err++; $display("FAIL ferr_retry_mem: got %h expected a7", rd); end
    endtask

    task automatic test_reset_mid_read;
        logic [12:0] tx;
        int w0, f0;
        tx = {1'b1, 4'hA, 8'h00};
        @(posedge clk); #1;
        SS = 1'b0;
        for (int i = 12; i >= 5; i--) begin
            MOSI = tx[i]; #HALF; SCK = 1'b1; #HALF; SCK = 1'b0;
        end
        MOSI = 1'b0; #HALF;
        n_vec++; if (MISO !== 1'b1)      begin n_err++; $display("FAIL midread_bit4: got %b expected 1", MISO); end
        n_vec++; if (miso_oe !== 1'b1)   begin n_err++; $display("FAIL midread_oe: got %b expected 1", miso_oe); end
        SCK = 1'b1; #20;
        w0 = wr_cnt; f0 = ferr_cnt;
        rst_n = 1'b0; #1;
        n_vec++; if (MISO !== 1'b0)      begin n_err++; $display("FAIL rst_miso: got %b expected 0", MISO); end
        n_vec++; if (miso_oe !== 1'b0)   begin n_err++; $display("FAIL rst_oe: got %b expected 0", miso_oe); end
        #59; SCK = 1'b0; SS = 1'b1; #100;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        n_vec++; if (ferr_cnt !== f0)    begin n_err++; $display("FAIL rst_no_ferr: got %0d expected 0", ferr_cnt - f0); end
        n_vec++; if (wr_cnt !== w0)      begin n_err++; $display("FAIL rst_no_write: got %0d expected 0", wr_cnt - w0); end
        spi_frame({51'd0, 1'b1, 4'hA, 8'h00}, 13, rx, oe_all);
        n_vec++; if (rx[7:0] !== 8'h00)  begin n_err++; $display("FAIL rst_mem_cleared: got %h expected 00", rx[7:0]); end
        spi_frame({51'd0, 1'b0, 4'h5, 8'h3C}, 13, rx, oe_all);
        spi_frame({51'd0, 1'b1, 4'h5, 8'h00}, 13, rx, oe_all);
        n_vec++; if (rx[7:0] !== 8'h3C)  begin n_err++; $display("FAIL post_rst_read: got %h expected 3c", rx[7:0]); end
    endtask

    task automatic test_mem_initial;
        logic [12:0] tx;
        int w0;
        tx = {1'b0, 4'h7, 8'h99};
        w0 = wr_cnt;
        @(posedge clk); #1;
        SS = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            MOSI = tx[i]; #HALF;
            SCK = 1'b1;
            if (i == 0) begin
                mem_initial = 1'b1; #60; mem_initial = 1'b0; #(HALF-60);
            end else begin
                #HALF;
            end
            SCK = 1'b0;
        end
        #HALF; SS = 1'b1; #(4*HALF);
        n_vec++; if (wr_cnt !== w0)      begin n_err++; $display("FAIL meminit_no_wr_valid: got %0d expected 0", wr_cnt - w0); end
        for (int a = 0; a < 16; a++) begin
            lcl_read(4'(a), rd);
            n_vec++; if (rd !== 8'h00)   begin n_err++; $display("FAIL meminit_clear[%0d]: got %h expected 00", a, rd); end
        end
        spi_frame({51'd0, 1'b1, 4'h7, 8'h00}, 13, rx, oe_all);
        n_vec++; if (rx[7:0] !== 8'h00)  begin n_err++; $display("FAIL meminit_read7: got %h expected 00", rx[7:0]); end
        spi_frame({51'd0, 1'b0, 4'h7, 8'h42}, 13, rx, oe_all);
        lcl_read(4'h7, rd);
        n_vec++; if (rd !== 8'h42)       begin n_err++; $display("FAIL meminit_rewrite: got %h expected 42", rd); end
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        test_reset;
        test_single_write;
        test_single_read;
        test_burst_wrap;
        test_frame_error;
        test_reset_mid_read;
        test_mem_initial;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
